// File: rtl/zerosoc_uart_pkg.sv
// Shared types and constants for the zerosoc UART receiver.
// The parity helper is only referenced when UART_RX_PARITY_EN is defined.
package zerosoc_uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 7;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Expected parity bit: even sense gives XOR of data, odd sense inverts it.
    function automatic logic parity_calc(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/zerosoc_uart_rx_baud_tick.sv
// Oversample tick generator: down-counter reloaded from the divisor plus a
// free-running 4-bit tick index; both are held at zero while clr_i is high.
module uart_rx_baud_tick
    import zerosoc_uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [DIV_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_tick;

    // First tick fires on the first cycle after clr_i drops, with index 0.
    assign w_tick = !clr_i && (r_cnt == {DIV_W{1'b0}});
    assign tick_o = w_tick;
    assign idx_o  = r_idx;

    // Divisor counter and tick index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= {DIV_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else if (clr_i) begin
            r_cnt <= {DIV_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else if (w_tick) begin
            r_cnt <= div_i;
            r_idx <= r_idx + 4'd1;
        end else begin
            r_cnt <= r_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/zerosoc_uart_rx.sv
// UART byte receiver, 16x oversampled, valid/ready output with overrun detection.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module zerosoc_uart_rx
    import zerosoc_uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_odd_i,
    input  logic             rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overrun_o
);

    localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(SAMPLE_MID);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e        r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_prev;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ferr;
    logic             r_perr;
    logic             r_ovr;
    logic             w_tick;
    logic [IDX_W-1:0] w_idx;
    logic             w_mid;
    logic             w_fall;
    logic             w_par_fail;

`ifdef UART_RX_PARITY_EN
    logic             r_par_err;
    assign w_par_fail = r_par_err;
`else
    logic             w_unused_par;
    assign w_unused_par = parity_odd_i;
    assign w_par_fail   = 1'b0;
`endif

    uart_rx_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (r_state == RX_IDLE),
        .div_i  (baud_div_i),
        .tick_o (w_tick),
        .idx_o  (w_idx)
    );

    assign w_mid  = w_tick && (w_idx == MID_IDX);
    assign w_fall = !r_rx_s && r_rx_prev;

    assign rx_data_o    = r_data;
    assign rx_valid_o   = r_valid;
    assign frame_err_o  = r_ferr;
    assign parity_err_o = r_perr;
    assign overrun_o    = r_ovr;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Frame FSM, shift register, holding register and error pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= RX_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_ferr <= 1'b0;
            r_perr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
            if (!enable_i) begin
                r_state <= RX_IDLE;
            end else begin
                case (r_state)
                    RX_IDLE: begin
                        if (w_fall) begin
                            r_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        r_bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
                        r_par_err <= 1'b0;
`endif
                        if (w_mid) begin
                            r_state <= r_rx_s ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (w_mid) begin
                            r_shift   <= {r_rx_s, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= RX_PARITY;
`else
                                r_state <= RX_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    RX_PARITY: begin
                        if (w_mid) begin
                            r_par_err <= (r_rx_s != parity_calc(r_shift, parity_odd_i));
                            r_state   <= RX_STOP;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (w_mid) begin
                            r_state <= RX_IDLE;
                            // A new byte while one is still held is dropped, not overwritten.
                            if (!r_rx_s) begin
                                r_ferr <= 1'b1;
                            end else if (w_par_fail) begin
                                r_perr <= 1'b1;
                            end else if (r_valid && !rx_ready_i) begin
                                r_ovr <= 1'b1;
                            end else begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zerosoc_uart_rx.sv
// Randomized bench for zerosoc_uart_rx: serial frames driven at the pad,
// outcomes predicted by a frame-level model of holding register and flags.
module tb_zerosoc_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [15:0] baud_div_i;
    logic        parity_odd_i;
    logic        rx_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        overrun_o;

    zerosoc_uart_rx #(.DIV_W(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .baud_div_i   (baud_div_i),
        .parity_odd_i (parity_odd_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_ovr   = 0;
    int n_wide  = 0;
    int ev_cyc  = 0;
    int bitp    = 64;
    logic [7:0] acc_q[$];
    logic p_valid = 1'b0;
    logic p_ferr  = 1'b0;
    logic p_perr  = 1'b0;
    logic p_ovr   = 1'b0;

    bit         m_held = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Observe handshakes, error pulses and when each frame's outcome appeared.
    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) acc_q.push_back(rx_data_o);
        if (frame_err_o)  n_ferr <= n_ferr + 1;
        if (parity_err_o) n_perr <= n_perr + 1;
        if (overrun_o)    n_ovr  <= n_ovr + 1;
        if ((frame_err_o && p_ferr) || (parity_err_o && p_perr) || (overrun_o && p_ovr))
            n_wide <= n_wide + 1;
        if ((rx_valid_o && !p_valid) || frame_err_o || parity_err_o || overrun_o)
            ev_cyc <= cyc;
        p_valid <= rx_valid_o;
        p_ferr  <= frame_err_o;
        p_perr  <= parity_err_o;
        p_ovr   <= overrun_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_div(input int d);
        baud_div_i = 16'(d);
        bitp = 16 * (d + 1);
    endtask

    task automatic release_held(input string tag);
        rx_ready_i = 1'b1;
        tick(2);
        check_eq({tag, "_acc_n"}, acc_q.size(), 1);
        if (acc_q.size() > 0) check_eq({tag, "_acc_data"}, acc_q[0], m_data);
        acc_q.delete();
        m_held = 1'b0;
        check_eq({tag, "_valid_clr"}, rx_valid_o, 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bad,
                              input bit abort, input string tag);
        logic [10:0] fr;
        int nb, fstart, s_f, s_p, s_o, off;
        bit pb, good, exp_acc;
        fr = 11'h7FF;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9]  = (^b) ^ parity_odd_i ^ par_bad;
        fr[10] = stop_bit;
        nb = 11;
        pb = par_bad;
`else
        fr[9] = stop_bit;
        nb = 10;
        pb = 1'b0;
`endif
        acc_q.delete();
        s_f = n_ferr; s_p = n_perr; s_o = n_ovr;
        fstart = cyc;
        for (int i = 0; i < nb; i++) begin
            rx_i = fr[i];
            if (abort && i == 4) enable_i = 1'b0;
            tick(bitp);
        end
        rx_i = 1'b1;
        tick(bitp);
        enable_i = 1'b1;
        tick(2);
        if (abort) begin
            check_eq({tag, "_abort_flags"}, (n_ferr - s_f) + (n_perr - s_p) + (n_ovr - s_o), 0);
            check_eq({tag, "_abort_acc"}, acc_q.size(), 0);
        end else begin
            good    = stop_bit && !pb;
            exp_acc = good && !m_held && rx_ready_i;
            check_eq({tag, "_ferr"}, n_ferr - s_f, {31'd0, !stop_bit});
            check_eq({tag, "_perr"}, n_perr - s_p, {31'd0, stop_bit && pb});
            check_eq({tag, "_ovr"},  n_ovr - s_o,  {31'd0, good && m_held});
            check_eq({tag, "_acc_n"}, acc_q.size(), {31'd0, exp_acc});
            if (exp_acc && acc_q.size() > 0) check_eq({tag, "_acc_data"}, acc_q[0], b);
            if (good && !m_held && !rx_ready_i) begin
                m_held = 1'b1;
                m_data = b;
            end
            // Outcome must appear inside the stop bit, after its first quarter.
            off = ev_cyc - fstart - (nb - 1) * bitp;
            check_eq({tag, "_window"}, (off >= bitp / 4) && (off < bitp), 1);
        end
        acc_q.delete();
        check_eq({tag, "_valid"}, rx_valid_o, {31'd0, m_held});
        if (m_held) check_eq({tag, "_data"}, rx_data_o, m_data);
    endtask

    initial begin
        int s_f, s_p, s_o;
        rst_ni       = 1'b0;
        enable_i     = 1'b1;
        parity_odd_i = 1'b0;
        rx_i         = 1'b1;
        rx_ready_i   = 1'b0;
        set_div(3);
        tick(3);
        check_eq("rst_data",  rx_data_o, 0);
        check_eq("rst_valid", rx_valid_o, 0);
        check_eq("rst_ferr",  frame_err_o, 0);
        check_eq("rst_perr",  parity_err_o, 0);
        check_eq("rst_ovr",   overrun_o, 0);
        rst_ni = 1'b1;
        tick(5);

        rx_ready_i = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5");

        // False start: short low glitch, then a real byte.
        s_f = n_ferr; s_p = n_perr; s_o = n_ovr;
        acc_q.delete();
        rx_i = 1'b0;
        tick(20);
        rx_i = 1'b1;
        tick(bitp * 12);
        check_eq("fstart_flags", (n_ferr - s_f) + (n_perr - s_p) + (n_ovr - s_o), 0);
        check_eq("fstart_acc", acc_q.size(), 0);
        check_eq("fstart_valid", rx_valid_o, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, "3c");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "ferr");

        // Line break: one frame error, no re-trigger while the line stays low.
        s_f = n_ferr; s_p = n_perr; s_o = n_ovr;
        acc_q.delete();
        rx_i = 1'b0;
        tick(bitp * 30);
        rx_i = 1'b1;
        tick(bitp * 2);
        check_eq("break_ferr", n_ferr - s_f, 1);
        check_eq("break_other", (n_perr - s_p) + (n_ovr - s_o) + acc_q.size(), 0);

        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, "hold11");
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, "ovr22");
        release_held("rel11");

`ifdef UART_RX_PARITY_EN
        parity_odd_i = 1'b1;
        rx_ready_i   = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, "par_bad");
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, "par_ok");
        parity_odd_i = 1'b0;
        send_frame(8'hE1, 1'b1, 1'b1, 1'b0, "par_even_bad");
`endif

        rx_ready_i = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, "abort");
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, "post_abort");

        // Asynchronous reset in the middle of the data bits.
        rx_ready_i = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0, 1'b0, "hold77");
        rx_i = 1'b0;
        tick(bitp);
        for (int i = 0; i < 3; i++) begin
            rx_i = i[0];
            tick(bitp);
        end
        tick(bitp / 2);
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_valid", rx_valid_o, 0);
        check_eq("midrst_data",  rx_data_o, 0);
        check_eq("midrst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 0);
        m_held = 1'b0;
        rx_i = 1'b1;
        tick(bitp * 8);
        rst_ni = 1'b1;
        tick(4);
        rx_ready_i = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, "5a");

        set_div(0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, "div0_ff");
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, "div0_00");

        for (int k = 0; k < 20; k++) begin
            bit rdy;
            set_div($urandom_range(0, 3));
            parity_odd_i = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0);
            if (rdy && m_held) release_held("rnd_rel");
            rx_ready_i = rdy;
            send_frame(8'($urandom), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 3) == 0), 1'b0, "rnd");
        end
        if (m_held) release_held("final_rel");

        check_eq("pulse_width", n_wide, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
